pll_div_bank: RTL and testbench

Cycle-accurate, synthesisable successor to the behavioural PLL output stage: a bank of NUM_OUT programmable counter dividers clocked directly by a VCO-rate clock. Each channel supports integer divide, high-time (duty) and phase delay in VCO ticks. A valid/ready port reconfigures channels glitch-free at period boundaries. LOCKED is derived from a settle counter, not from measured periods. It sits behind a VCO source and replaces the real-time freq_gen/phase_shift pair where deterministic, clock-cycle timing is required.

---
 rtl/pll_div_pkg.sv | 24 ++
 rtl/div_channel.sv | 143 ++++++++++++++
 rtl/pll_div_bank.sv | 84 ++++++++
 tb/tb_pll_div_bank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_div_pkg.sv
// rtl/pll_div_pkg.sv - shared channel state type, channel-index width and config validity check
package pll_div_pkg;

    typedef enum logic [1:0] {
        CH_START = 2'd0,
        CH_DELAY = 2'd1,
        CH_RUN   = 2'd2
    } ch_state_t;

    // Channel index width; a single-channel bank still needs a 1-bit select.
    function automatic int ch_width(input int num_out);
        return (num_out <= 1) ? 1 : $clog2(num_out);
    endfunction

    // A request is legal only if it names a real channel and the waveform
    // fields describe a period with at least one high and one low cycle.
    function automatic logic cfg_ok(input int unsigned ch, input int unsigned num_out,
                                    input int unsigned divide, input int unsigned high,
                                    input int unsigned phase);
        return (ch < num_out) && (divide >= 2) && (high >= 1) &&
               (high <= divide - 1) && (phase <= divide - 1);
    endfunction

endpackage

// File: rtl/div_channel.sv
// rtl/div_channel.sv - one programmable divider channel with pending config applied at period boundary
module div_channel import pll_div_pkg::*; #(
    parameter int CNT_W          = 8,
    parameter int DEFAULT_DIVIDE = 2,
    parameter int DEFAULT_HIGH   = 1,
    parameter int DEFAULT_PHASE  = 0
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_pwrdwn,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_divide,
    input  logic [CNT_W-1:0] i_high,
    input  logic [CNT_W-1:0] i_phase,
    output logic             o_clk,
    output logic             o_running,
    output logic             o_pending
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIVIDE);
    localparam logic [CNT_W-1:0] DEF_HI  = CNT_W'(DEFAULT_HIGH);
    localparam logic [CNT_W-1:0] DEF_PH  = CNT_W'(DEFAULT_PHASE);

    ch_state_t        r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n, r_dly, w_dly_n;
    logic [CNT_W-1:0] r_div, w_div_n, r_high, w_high_n, r_phase, w_phase_n;
    logic [CNT_W-1:0] r_pdiv, w_pdiv_n, r_phigh, w_phigh_n, r_pphase, w_pphase_n;
    logic             r_pend, w_pend_n, r_clk, w_clk_n, w_boundary;

    assign w_boundary = (r_state == CH_RUN) && (r_cnt == r_div - ONE);

    // Next-state: power-down parks in START and promotes pending; otherwise run the divider
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_dly_n    = r_dly;
        w_div_n    = r_div;
        w_high_n   = r_high;
        w_phase_n  = r_phase;
        w_pdiv_n   = r_pdiv;
        w_phigh_n  = r_phigh;
        w_pphase_n = r_pphase;
        w_pend_n   = r_pend;
        if (i_pwrdwn) begin
            w_state_n = CH_START;
            w_cnt_n   = '0;
            w_dly_n   = '0;
            if (r_pend) begin
                w_div_n   = r_pdiv;
                w_high_n  = r_phigh;
                w_phase_n = r_pphase;
                w_pend_n  = 1'b0;
            end
            // No boundary to wait for while powered down, so writes go straight to active.
            if (i_wr) begin
                w_div_n   = i_divide;
                w_high_n  = i_high;
                w_phase_n = i_phase;
            end
        end else begin
            case (r_state)
                CH_START: begin
                    w_cnt_n = '0;
                    if (r_phase == '0) begin
                        w_state_n = CH_RUN;
                    end else begin
                        w_state_n = CH_DELAY;
                        w_dly_n   = r_phase - ONE;
                    end
                end
                CH_DELAY: begin
                    if (r_dly == '0) begin
                        w_state_n = CH_RUN;
                        w_cnt_n   = '0;
                    end else begin
                        w_dly_n = r_dly - ONE;
                    end
                end
                CH_RUN: begin
                    if (w_boundary) begin
                        w_cnt_n = '0;
                        if (r_pend) begin
                            w_div_n   = r_pdiv;
                            w_high_n  = r_phigh;
                            w_phase_n = r_pphase;
                            w_pend_n  = 1'b0;
                            if (r_pphase != '0) begin
                                w_state_n = CH_DELAY;
                                w_dly_n   = r_pphase - ONE;
                            end
                        end
                    end else begin
                        w_cnt_n = r_cnt + ONE;
                    end
                end
                default: w_state_n = CH_START;
            endcase
            // Written after the boundary logic so a same-edge request waits a full period.
            if (i_wr) begin
                w_pend_n   = 1'b1;
                w_pdiv_n   = i_divide;
                w_phigh_n  = i_high;
                w_pphase_n = i_phase;
            end
        end
        w_clk_n = (w_state_n == CH_RUN) && (w_cnt_n < w_high_n);
    end

    // State, configuration and registered clock output
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state  <= CH_START;
            r_cnt    <= '0;
            r_dly    <= '0;
            r_div    <= DEF_DIV;
            r_high   <= DEF_HI;
            r_phase  <= DEF_PH;
            r_pdiv   <= '0;
            r_phigh  <= '0;
            r_pphase <= '0;
            r_pend   <= 1'b0;
            r_clk    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_dly    <= w_dly_n;
            r_div    <= w_div_n;
            r_high   <= w_high_n;
            r_phase  <= w_phase_n;
            r_pdiv   <= w_pdiv_n;
            r_phigh  <= w_phigh_n;
            r_pphase <= w_pphase_n;
            r_pend   <= w_pend_n;
            r_clk    <= w_clk_n;
        end
    end

    assign o_clk     = r_clk;
    assign o_running = (r_state == CH_RUN);
    assign o_pending = r_pend;

endmodule

// File: rtl/pll_div_bank.sv
// rtl/pll_div_bank.sv - bank of programmable VCO dividers with config port and settle-based lock
module pll_div_bank import pll_div_pkg::*; #(
    parameter  int NUM_OUT        = 7,
    parameter  int CNT_W          = 8,
    parameter  int LOCK_CYCLES    = 64,
    parameter  int DEFAULT_DIVIDE = 2,
    parameter  int DEFAULT_HIGH   = 1,
    parameter  int DEFAULT_PHASE  = 0,
    localparam int CH_W           = ch_width(NUM_OUT)
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               PWRDWN,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_divide,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [CNT_W-1:0]   cfg_phase,
    output logic               cfg_err,
    output logic [NUM_OUT-1:0] clk_out,
    output logic               LOCKED
);

    localparam logic [15:0] LOCK_MAX = 16'(LOCK_CYCLES);

    logic [NUM_OUT-1:0] w_wr, w_run, w_pend;
    logic               w_accept, w_ok, r_err, r_locked;
    logic [15:0]        r_lock_cnt, w_lock_n;

    assign w_accept  = cfg_valid && cfg_ready;
    assign w_ok      = cfg_ok(32'(cfg_ch), 32'(NUM_OUT), 32'(cfg_divide),
                              32'(cfg_high), 32'(cfg_phase));
    // Only one update is ever in flight, so the bank is ready when no channel holds one.
    assign cfg_ready = ~|w_pend;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
        assign w_wr[g] = w_accept && w_ok && (cfg_ch == CH_W'(g));
        div_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_DIVIDE (DEFAULT_DIVIDE),
            .DEFAULT_HIGH   (DEFAULT_HIGH),
            .DEFAULT_PHASE  (DEFAULT_PHASE)
        ) u_ch (
            .clk       (clk),
            .i_rst     (RST),
            .i_pwrdwn  (PWRDWN),
            .i_wr      (w_wr[g]),
            .i_divide  (cfg_divide),
            .i_high    (cfg_high),
            .i_phase   (cfg_phase),
            .o_clk     (clk_out[g]),
            .o_running (w_run[g]),
            .o_pending (w_pend[g])
        );
    end

    // Settle counter: restarts whenever the bank is not uniformly running, saturates at the target
    always_comb begin
        w_lock_n = r_lock_cnt;
        if (PWRDWN || (|w_pend) || !(&w_run)) begin
            w_lock_n = '0;
        end else if (r_lock_cnt != LOCK_MAX) begin
            w_lock_n = r_lock_cnt + 16'd1;
        end
    end

    // Lock counter, registered LOCKED and the one-cycle reject pulse
    always_ff @(posedge clk) begin
        if (RST) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_lock_cnt <= w_lock_n;
            r_locked   <= (w_lock_n == LOCK_MAX);
            r_err      <= w_accept && !w_ok;
        end
    end

    assign cfg_err = r_err;
    assign LOCKED  = r_locked;

endmodule

// File: tb/tb_pll_div_bank.sv
// tb/tb_pll_div_bank.sv - scenario and randomized checks of pll_div_bank against a timeline model
`timescale 1ns/1ps
module tb_pll_div_bank;

    localparam int NUM   = 7;
    localparam int LOCKN = 64;

    logic       clk = 1'b0;
    logic       RST = 1'b1, PWRDWN = 1'b0, cfg_valid = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [7:0] cfg_divide = '0, cfg_high = '0, cfg_phase = '0;
    logic       cfg_ready, cfg_err, LOCKED;
    logic [6:0] clk_out;

    pll_div_bank dut (
        .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_divide(cfg_divide), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .clk_out(clk_out), .LOCKED(LOCKED)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int n = 0;

    // Model: each channel's waveform is a timeline starting at edge m_seg;
    // after m_p low edges it repeats a period of m_d with m_h high edges.
    int m_d[NUM], m_h[NUM], m_p[NUM], m_seg[NUM];
    bit m_started[NUM];
    bit m_pv, m_err;
    int m_pch, m_pd, m_ph, m_pp;
    int streak = 0;

    function automatic bit m_legal(int ch, int d, int h, int p);
        return (ch < NUM) && (d >= 2) && (h >= 1) && (h <= d - 1) && (p <= d - 1);
    endfunction

    function automatic bit m_run(int ch, int e);
        return m_started[ch] && (e - m_seg[ch] - m_p[ch] >= 0);
    endfunction

    function automatic bit m_bit(int ch, int e);
        int k = e - m_seg[ch] - m_p[ch];
        return m_started[ch] && (k >= 0) && ((k % m_d[ch]) < m_h[ch]);
    endfunction

    function automatic bit m_last(int ch, int e);
        int k = e - m_seg[ch] - m_p[ch];
        return m_started[ch] && (k >= 0) && ((k % m_d[ch]) == m_d[ch] - 1);
    endfunction

    function automatic logic [9:0] m_vec();
        logic [9:0] v;
        for (int c = 0; c < NUM; c++) v[3 + c] = m_bit(c, n);
        v[2] = !m_pv;
        v[1] = m_err;
        v[0] = (streak >= LOCKN);
        return v;
    endfunction

    task automatic tick();
        bit cond, acc, ok;
        int ch;
        @(posedge clk);
        cond = !RST && !PWRDWN && !m_pv;
        for (int c = 0; c < NUM; c++) if (!m_run(c, n)) cond = 1'b0;
        acc = cfg_valid && !m_pv;
        ch  = int'(cfg_ch);
        ok  = m_legal(ch, int'(cfg_divide), int'(cfg_high), int'(cfg_phase));
        n++;
        if (RST) begin
            for (int c = 0; c < NUM; c++) begin
                m_d[c] = 2; m_h[c] = 1; m_p[c] = 0; m_started[c] = 1'b0;
            end
            m_pv = 1'b0; m_err = 1'b0;
        end else begin
            m_err = acc && !ok;
            if (PWRDWN) begin
                for (int c = 0; c < NUM; c++) m_started[c] = 1'b0;
                if (m_pv) begin
                    m_d[m_pch] = m_pd; m_h[m_pch] = m_ph; m_p[m_pch] = m_pp; m_pv = 1'b0;
                end
                if (acc && ok) begin
                    m_d[ch] = int'(cfg_divide); m_h[ch] = int'(cfg_high); m_p[ch] = int'(cfg_phase);
                end
            end else begin
                for (int c = 0; c < NUM; c++) begin
                    if (!m_started[c]) begin
                        m_started[c] = 1'b1; m_seg[c] = n;
                    end else if (m_pv && m_pch == c && m_last(c, n - 1)) begin
                        m_d[c] = m_pd; m_h[c] = m_ph; m_p[c] = m_pp; m_seg[c] = n; m_pv = 1'b0;
                    end
                end
                if (acc && ok) begin
                    m_pv = 1'b1; m_pch = ch;
                    m_pd = int'(cfg_divide); m_ph = int'(cfg_high); m_pp = int'(cfg_phase);
                end
            end
        end
        streak = cond ? streak + 1 : 0;
        @(negedge clk);
    endtask

    task automatic drive(int ch, int d, int h, int p);
        cfg_valid = 1'b1; cfg_ch = 3'(ch);
        cfg_divide = 8'(d); cfg_high = 8'(h); cfg_phase = 8'(p);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) begin
            tick();
            total++;
            if ({clk_out, cfg_ready, cfg_err, LOCKED} !== 10'b0000000_1_0_0)
                $display("FAIL reset: got %b want %b", {clk_out, cfg_ready, cfg_err, LOCKED}, 10'b0000000_1_0_0);
            else passed++;
        end
    endtask

    task automatic test_defaults();
        int rel, first_lock;
        RST = 1'b0; rel = n + 1; first_lock = -1;
        for (int i = 0; i < 110; i++) begin
            tick();
            total++;
            if ({clk_out, cfg_ready, cfg_err, LOCKED} !== m_vec())
                $display("FAIL defaults edge %0d: got %b want %b", n, {clk_out, cfg_ready, cfg_err, LOCKED}, m_vec());
            else passed++;
            if (LOCKED && first_lock < 0) first_lock = n;
        end
        total++;
        if (first_lock - rel !== LOCKN)
            $display("FAIL lock_delay: got %0d want %0d", first_lock - rel, LOCKN);
        else passed++;
    endtask

    task automatic test_reconfig();
        int w = 0;
        while (!(cfg_ready && clk_out[3]) && w < 10) begin tick(); w++; end
        drive(3, 10, 3, 4);
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 150; i++) begin
            total++;
            if ({clk_out, cfg_ready, cfg_err, LOCKED} !== m_vec())
                $display("FAIL reconfig edge %0d: got %b want %b", n, {clk_out, cfg_ready, cfg_err, LOCKED}, m_vec());
            else passed++;
            tick();
        end
    endtask

    task automatic test_boundary();
        int w = 0;
        while (!(cfg_ready && LOCKED && !clk_out[0]) && w < 200) begin tick(); w++; end
        total++;
        if (w >= 200) $display("FAIL boundary_wait: got timeout want ready+locked");
        else passed++;
        drive(0, 6, 2, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            cfg_valid = 1'b0;
            total++;
            if ({clk_out, cfg_ready, cfg_err, LOCKED} !== m_vec())
                $display("FAIL boundary edge %0d: got %b want %b", n, {clk_out, cfg_ready, cfg_err, LOCKED}, m_vec());
            else passed++;
        end
    endtask

    task automatic test_invalid();
        int bad[4][4] = '{'{7, 4, 1, 0}, '{1, 1, 0, 0}, '{2, 5, 5, 0}, '{4, 5, 2, 5}};
        int errs = 0, unlocked = 0, w = 0;
        while (!(cfg_ready && LOCKED) && w < 200) begin tick(); w++; end
        for (int r = 0; r < 4; r++) begin
            drive(bad[r][0], bad[r][1], bad[r][2], bad[r][3]);
            for (int i = 0; i < 3; i++) begin
                tick();
                cfg_valid = 1'b0;
                if (cfg_err) errs++;
                if (!LOCKED) unlocked++;
                total++;
                if ({clk_out, cfg_ready, cfg_err, LOCKED} !== m_vec())
                    $display("FAIL invalid edge %0d: got %b want %b", n, {clk_out, cfg_ready, cfg_err, LOCKED}, m_vec());
                else passed++;
            end
        end
        total++;
        if (errs !== 4) $display("FAIL invalid_err_count: got %0d want 4", errs);
        else passed++;
        total++;
        if (unlocked !== 0) $display("FAIL invalid_lock: got %0d unlocked samples want 0", unlocked);
        else passed++;
    endtask

    task automatic test_pwrdwn();
        int w = 0;
        while (!(cfg_ready && clk_out[3]) && w < 40) begin tick(); w++; end
        drive(3, 8, 4, 2);
        tick();
        cfg_valid = 1'b0;
        PWRDWN = 1'b1;
        tick();
        total++;
        if ({clk_out, cfg_ready, LOCKED} !== 9'b0000000_1_0)
            $display("FAIL pwrdwn_entry: got %b want %b", {clk_out, cfg_ready, LOCKED}, 9'b0000000_1_0);
        else passed++;
        for (int i = 0; i < 100; i++) begin
            if (i == 3) PWRDWN = 1'b0;
            tick();
            total++;
            if ({clk_out, cfg_ready, cfg_err, LOCKED} !== m_vec())
                $display("FAIL pwrdwn edge %0d: got %b want %b", n, {clk_out, cfg_ready, cfg_err, LOCKED}, m_vec());
            else passed++;
        end
    endtask

    task automatic test_rst_delay();
        int w = 0;
        while (!cfg_ready && w < 40) begin tick(); w++; end
        drive(5, 20, 5, 15);
        for (int i = 0; i < 8; i++) begin
            tick();
            cfg_valid = 1'b0;
            if (i == 6) RST = 1'b1;
            total++;
            if ({clk_out, cfg_ready, cfg_err, LOCKED} !== m_vec())
                $display("FAIL rst_delay edge %0d: got %b want %b", n, {clk_out, cfg_ready, cfg_err, LOCKED}, m_vec());
            else passed++;
        end
        RST = 1'b0;
        tick();
        total++;
        if (clk_out !== 7'h7f) $display("FAIL rst_release: got %b want %b", clk_out, 7'h7f);
        else passed++;
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if ({clk_out, cfg_ready, cfg_err, LOCKED} !== m_vec())
                $display("FAIL rst_after edge %0d: got %b want %b", n, {clk_out, cfg_ready, cfg_err, LOCKED}, m_vec());
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = 3'($urandom_range(0, 7));
            cfg_divide = 8'($urandom_range(0, 12));
            cfg_high   = 8'($urandom_range(0, 12));
            cfg_phase  = 8'($urandom_range(0, 12));
            PWRDWN     = ($urandom_range(0, 59) == 0);
            RST        = ($urandom_range(0, 249) == 0);
            tick();
            total++;
            if ({clk_out, cfg_ready, cfg_err, LOCKED} !== m_vec())
                $display("FAIL random edge %0d: got %b want %b", n, {clk_out, cfg_ready, cfg_err, LOCKED}, m_vec());
            else passed++;
        end
        cfg_valid = 1'b0; PWRDWN = 1'b0; RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_reconfig();
        test_boundary();
        test_invalid();
        test_pwrdwn();
        test_rst_delay();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
